// File: rtl/counter12_down.sv
// counter12_down: modulo-12 down counter with synchronous load, cascadable borrow and clamped illegal loads.
module counter12_down #(
  parameter logic [3:0] RESET_VALUE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       zero,
  output logic       borrow,
  output logic       load_err
);
  logic       bad_d;
  logic [3:0] q_nxt;
  // Any state outside 0..11, or zero, reloads 11 when counting, so upsets self-heal.
  always_comb begin
    bad_d = d > 4'd11;
    q_nxt = load ? (bad_d ? 4'd11 : d) :
            en   ? ((q == 4'd0 || q > 4'd11) ? 4'd11 : q - 4'd1) : q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q        <= RESET_VALUE;
      load_err <= 1'b0;
    end else begin
      q        <= q_nxt;
      load_err <= load & bad_d;
    end
  assign zero   = q == 4'd0;
  assign borrow = en & zero;
endmodule

// File: tb/tb_counter12_down.sv
// tb_counter12_down: vector table, directed corner cases and random stimulus against an arithmetic model.
module tb_counter12_down;
  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, load = 1'b0;
  logic [3:0] d = 4'd0;
  logic [3:0] q;
  logic       zero, borrow, load_err;
  logic       c_load = 1'b0, c_en = 1'b0;
  logic [3:0] lo_q, hi_q;
  logic       lo_zero, lo_borrow, lo_err, hi_zero, hi_borrow, hi_err;

  counter12_down dut (.clk(clk), .rst_n(rst_n), .en(en), .load(load), .d(d),
                      .q(q), .zero(zero), .borrow(borrow), .load_err(load_err));
  counter12_down lo (.clk(clk), .rst_n(rst_n), .en(c_en), .load(c_load), .d(4'd0),
                     .q(lo_q), .zero(lo_zero), .borrow(lo_borrow), .load_err(lo_err));
  counter12_down hi (.clk(clk), .rst_n(rst_n), .en(lo_borrow), .load(c_load), .d(4'd0),
                     .q(hi_q), .zero(hi_zero), .borrow(hi_borrow), .load_err(hi_err));

  always #5 clk = ~clk;

  int total = 0, passed = 0;
  int m_q = 0, m_err = 0;

  typedef struct {
    logic       l;
    logic       e;
    logic [3:0] dv;
    int         eq;
    int         eerr;
  } vec_t;
  vec_t vt[13];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic step(input logic l, input logic e, input logic [3:0] dv);
    load = l; en = e; d = dv;
    @(posedge clk); #1;
    if (l) begin
      m_err = int'(dv > 4'd11);
      m_q   = dv > 4'd11 ? 11 : int'(dv);
    end else begin
      m_err = 0;
      if (e) m_q = (m_q + 11) % 12;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " q"}, int'(q), m_q);
    chk({tag, " zero"}, int'(zero), int'(m_q == 0));
    chk({tag, " borrow"}, int'(borrow), int'(en && m_q == 0));
    chk({tag, " load_err"}, int'(load_err), m_err);
  endtask

  initial begin
    int nb, lm, hm;
    vt[0]  = '{1'b1, 1'b1, 4'd7,  7,  0};
    vt[1]  = '{1'b0, 1'b1, 4'd0,  6,  0};
    vt[2]  = '{1'b0, 1'b1, 4'd0,  5,  0};
    vt[3]  = '{1'b0, 1'b1, 4'd0,  4,  0};
    vt[4]  = '{1'b1, 1'b0, 4'd13, 11, 1};
    vt[5]  = '{1'b0, 1'b0, 4'd0,  11, 0};
    vt[6]  = '{1'b1, 1'b0, 4'd15, 11, 1};
    vt[7]  = '{1'b1, 1'b1, 4'd12, 11, 1};
    vt[8]  = '{1'b1, 1'b0, 4'd0,  0,  0};
    vt[9]  = '{1'b0, 1'b1, 4'd0,  11, 0};
    vt[10] = '{1'b1, 1'b0, 4'd1,  1,  0};
    vt[11] = '{1'b0, 1'b1, 4'd0,  0,  0};
    vt[12] = '{1'b0, 1'b0, 4'd0,  0,  0};

    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset q", int'(q), 0);
    chk("reset zero", int'(zero), 1);
    chk("reset load_err", int'(load_err), 0);
    chk("reset borrow", int'(borrow), 1);
    rst_n = 1'b1;

    nb = 0;
    for (int i = 1; i <= 25; i++) begin
      step(1'b0, 1'b1, 4'd0);
      chk("free q", int'(q), (12 - i % 12) % 12);
      chk("free borrow", int'(borrow), int'(q == 4'd0));
      if (borrow) nb++;
    end
    chk("free borrow count", nb, 2);

    foreach (vt[i]) begin
      step(vt[i].l, vt[i].e, vt[i].dv);
      chk($sformatf("vec%0d q", i), int'(q), vt[i].eq);
      chk($sformatf("vec%0d load_err", i), int'(load_err), vt[i].eerr);
      chk($sformatf("vec%0d zero", i), int'(zero), int'(vt[i].eq == 0));
      chk($sformatf("vec%0d borrow", i), int'(borrow), int'(vt[i].e && vt[i].eq == 0));
    end

    step(1'b1, 1'b0, 4'd14);
    chk("pre-reset load_err", int'(load_err), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset q", int'(q), 0);
    chk("async reset load_err", int'(load_err), 0);
    chk("async reset zero", int'(zero), 1);
    rst_n = 1'b1;
    m_q = 0; m_err = 0;

    repeat (300) begin
      step(1'($urandom_range(3) == 0), 1'($urandom_range(1)), 4'($urandom_range(15)));
      check_model("rand");
    end

    load = 1'b0; en = 1'b0;
    c_load = 1'b1; c_en = 1'b1;
    @(posedge clk); #1;
    c_load = 1'b0;
    chk("cascade lo load", int'(lo_q), 0);
    chk("cascade hi load", int'(hi_q), 0);
    lm = 0; hm = 0;
    for (int i = 1; i <= 13; i++) begin
      @(posedge clk); #1;
      if (lm == 0) hm = (hm + 11) % 12;
      lm = (lm + 11) % 12;
      chk($sformatf("cascade lo e%0d", i), int'(lo_q), lm);
      chk($sformatf("cascade hi e%0d", i), int'(hi_q), hm);
    end
    c_en = 1'b0;

    load = 1'b0; en = 1'b0;
    force dut.q = 4'd14;
    #1 release dut.q;
    #1;
    chk("illegal q", int'(q), 14);
    chk("illegal zero", int'(zero), 0);
    chk("illegal borrow", int'(borrow), 0);
    @(posedge clk); #1;
    chk("illegal hold q", int'(q), 14);
    en = 1'b1;
    #1;
    chk("illegal borrow en", int'(borrow), 0);
    @(posedge clk); #1;
    chk("illegal recover q", int'(q), 11);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/counter12_down.md
# counter12_down

Modulo-12 synchronous down counter: the count-down counterpart of the team's mod-12 up counter. It steps 11, 10, …, 1, 0, 11, … on enabled clock edges. It supports synchronous parallel load and a cascadable borrow output, so chains of mod-12 and mod-10 stages can form countdown timers. Illegal load values are clamped and flagged rather than propagated.

## Interface
- RESET_VALUE, 0, count value forced by reset; legal range 0..11.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous reset, active-low.
- en  input  1  count enable; when high on an edge, q decrements modulo 12.
- load  input  1  synchronous parallel load; has priority over en.
- d  input  4  load value; legal range 0..11.
- q  output  4  current count, unsigned binary, always 0..11.
- zero  output  1  combinational, high when q == 0.
- borrow  output  1  combinational, high when en == 1 and q == 0; drives the en of the next, more significant stage.
- load_err  output  1  registered, one-cycle pulse after a load with d > 11.

## Operation
- State: 4-bit count register q and 1-bit load_err flop. No other storage.
- Priority on each rising clk edge, with rst_n high:
  - load = 1:
    - If d ≤ 11, q ← d and load_err ← 0.
    - If d ≥ 12, q ← 11 and load_err ← 1.
  - load = 0, en = 1: q ← (q == 0) ? 11 : q − 1; load_err ← 0.
  - load = 0, en = 0: q holds; load_err ← 0.
- load and en both high: load wins and no decrement occurs. borrow may still be high combinationally if q == 0. The upstream stage is then responsible; this stage does not suppress it.
- Defensive decode: if q ever holds 12..15 (upset or X-recovery), the next edge with en = 1 and load = 0 forces q ← 11. With en = 0, q holds the illegal value, and zero and borrow stay low.
- borrow = en & (q == 0). It is purely combinational so that cascades count in the same edge with no added latency.
- The decrement uses a 4-bit subtract. The wrap is explicit via the q == 0 compare; there is no reliance on underflow to 15.

## Timing
- Reset (rst_n low, asynchronous, independent of clk): q = RESET_VALUE, load_err = 0. zero and borrow follow q and en combinationally; with the default RESET_VALUE, zero = 1.
- Reset release: the first edge with rst_n high may count or load. There is no extra idle cycle.
- Reset asserted mid-operation, including mid-load: the state immediately returns to the reset values and any pending load_err is cleared.
- Latency:
  - Load: d appears on q one edge after load is sampled.
  - Count: q changes on the edge where en is sampled high.
  - load_err is high for exactly the cycle following the offending load edge.
- Full period with en held high is 12 edges. borrow is high for 1 cycle in every 12.
- Back-to-back loads each take effect and each evaluate load_err independently; two bad loads in a row give load_err high for 2 cycles.

## Test plan
- Reset: hold rst_n = 0 with clk running and en = 1 → q = 0, zero = 1, load_err = 0. Assert rst_n mid-cycle between edges → q returns to 0 with no clock edge.
- Free count: from reset, en = 1 for 25 edges → q sequence 11, 10, …, 0, 11, …, 0, 11. borrow is high exactly in cycles where q == 0, twice in total.
- Load and priority: load = 1, en = 1, d = 7 → q = 7 next cycle with no decrement. Then en = 1 for 3 edges → q = 4.
- Illegal load: load = 1, d = 13 → q = 11 and load_err = 1 for one cycle. Then load d = 15 and load d = 12 back-to-back → load_err high 2 cycles, q = 11.
- Cascade: two instances, the low stage's borrow feeding the high stage's en, both loaded to 0, low en = 1 for 13 edges → high stage steps 0→11 at edge 1 and 11→10 at edge 13.
- Illegal-state recovery: force q = 14 via hierarchical deposit. With en = 0, q holds 14 and zero = 0. With en = 1 for one edge → q = 11.
